// File: rtl/folded_majority_bundler.sv
// Majority bundler fed one FOLD_WIDTH slice per beat, fold-major across NUM_MODALITY hypervectors.
// Optional macro BUNDLER_TIE_BREAK_EN: even-modality ties resolve to modality 0's bit.
module folded_majority_bundler #(
   parameter int HV_DIMENSION = 2000,
   parameter int FOLD_WIDTH   = 400,
   parameter int NUM_MODALITY = 3,
   localparam int NUM_FOLDS      = HV_DIMENSION / FOLD_WIDTH,
   localparam int FOLD_IDX_WIDTH = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
   localparam int MOD_IDX_WIDTH  = (NUM_MODALITY > 1) ? $clog2(NUM_MODALITY) : 1,
   localparam int CNT_WIDTH      = $clog2(NUM_MODALITY + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      hvin_valid,
   output logic                      hvin_ready,
   input  logic [FOLD_WIDTH-1:0]     hvin,
   output logic [FOLD_IDX_WIDTH-1:0] fold_idx,
   output logic [MOD_IDX_WIDTH-1:0]  mod_idx,
   output logic                      hvout_valid,
   input  logic                      hvout_ready,
   output logic [HV_DIMENSION-1:0]   hvout
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'(NUM_MODALITY / 2);

   state_t                state;
   logic [CNT_WIDTH-1:0]  cnt [HV_DIMENSION];
   logic [CNT_WIDTH-1:0]  fold_sum [FOLD_WIDTH];
   logic [FOLD_WIDTH-1:0] fold_maj;
   logic [FOLD_WIDTH-1:0] tie_bits;
   logic                  accept;
   logic                  last_mod;
   logic                  last_fold;

   assign hvin_ready = (state == ACCUM) && !clear;
   assign accept     = hvin_ready && hvin_valid;
   assign last_mod   = (mod_idx == MOD_IDX_WIDTH'(NUM_MODALITY - 1));
   assign last_fold  = (fold_idx == FOLD_IDX_WIDTH'(NUM_FOLDS - 1));

   // Counts of the active fold including the beat on hvin, and their majority vote.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      for (int b = 0; b < FOLD_WIDTH; b++) begin
         fold_sum[b] = '0;
      end
      for (int f = 0; f < NUM_FOLDS; f++) begin
         if (fold_idx == FOLD_IDX_WIDTH'(f)) begin
            for (int b = 0; b < FOLD_WIDTH; b++) begin
               fold_sum[b] = cnt[f*FOLD_WIDTH + b] + CNT_WIDTH'(hvin[b]);
            end
         end
      end
      for (int b = 0; b < FOLD_WIDTH; b++) begin
         fold_maj[b] = (fold_sum[b] > HALF) || ((fold_sum[b] == HALF) && tie_bits[b]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state uses <= so every register sees pre-edge values regardless of statement order.
      if (!rst_n) begin
         state       <= ACCUM;
         fold_idx    <= '0;
         mod_idx     <= '0;
         hvout_valid <= 1'b0;
         hvout       <= '0;
         // NOTE: the counter array is reset explicitly; every bundle relies on it starting at zero.
         cnt         <= '{default: '0};
      end else if (clear) begin
         state       <= ACCUM;
         fold_idx    <= '0;
         mod_idx     <= '0;
         hvout_valid <= 1'b0;
         cnt         <= '{default: '0};
      end else if (state == HOLD) begin
         if (hvout_ready) begin
            state       <= ACCUM;
            hvout_valid <= 1'b0;
         end
      end else if (accept) begin
         for (int f = 0; f < NUM_FOLDS; f++) begin
            if (fold_idx == FOLD_IDX_WIDTH'(f)) begin
               for (int b = 0; b < FOLD_WIDTH; b++) begin
                  cnt[f*FOLD_WIDTH + b] <= fold_sum[b];
               end
            end
         end
         if (last_mod) begin
            mod_idx <= '0;
            for (int f = 0; f < NUM_FOLDS; f++) begin
               if (fold_idx == FOLD_IDX_WIDTH'(f)) begin
                  hvout[f*FOLD_WIDTH +: FOLD_WIDTH] <= fold_maj;
               end
            end
            if (last_fold) begin
               // Later assignment wins: the whole array restarts at zero for the next bundle.
               fold_idx    <= '0;
               state       <= HOLD;
               hvout_valid <= 1'b1;
               cnt         <= '{default: '0};
            end else begin
               fold_idx <= fold_idx + FOLD_IDX_WIDTH'(1);
            end
         end else begin
            mod_idx <= mod_idx + MOD_IDX_WIDTH'(1);
         end
      end
   end

`ifdef BUNDLER_TIE_BREAK_EN
   localparam bit EVEN_MOD = (NUM_MODALITY % 2) == 0;

   logic [FOLD_WIDTH-1:0] tie_store;

   // Modality 0's slice of the active fold; odd modality counts never tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tie_store <= '0;
      end else if (clear || (accept && last_mod && last_fold)) begin
         tie_store <= '0;
      end else if (accept && (mod_idx == '0)) begin
         tie_store <= hvin;
      end
   end

   assign tie_bits = EVEN_MOD ? tie_store : '0;
`else
   assign tie_bits = '0;
`endif

endmodule

// File: tb/tb_folded_majority_bundler.sv
// Scoreboard bench: two bundlers (3 and 2 modalities, 8-bit HV, 4-bit folds) against a bit-count model.
`timescale 1ns/1ps
module tb_folded_majority_bundler;

   typedef logic [3:0] beats_t [6];

`ifdef BUNDLER_TIE_BREAK_EN
   localparam logic [7:0] TIE_EXP = 8'h0A;
`else
   localparam logic [7:0] TIE_EXP = 8'h02;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] clear_s, ivalid, iready, ovalid, oready;
   logic [3:0] hvin_s [2];
   logic [7:0] hvout_s [2];
   logic [0:0] fold0, fold1;
   logic [1:0] mod0;
   logic [0:0] mod1;
   logic [1:0] rdy_mode, rdy_force;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic [7:0] last_hv [2];
   bit         held [2];
   logic [7:0] hv_exp [2];

   always #5 clk = ~clk;

   folded_majority_bundler #(.HV_DIMENSION(8), .FOLD_WIDTH(4), .NUM_MODALITY(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear_s[0]), .hvin_valid(ivalid[0]),
      .hvin_ready(iready[0]), .hvin(hvin_s[0]), .fold_idx(fold0), .mod_idx(mod0),
      .hvout_valid(ovalid[0]), .hvout_ready(oready[0]), .hvout(hvout_s[0]));

   folded_majority_bundler #(.HV_DIMENSION(8), .FOLD_WIDTH(4), .NUM_MODALITY(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear_s[1]), .hvin_valid(ivalid[1]),
      .hvin_ready(iready[1]), .hvin(hvin_s[1]), .fold_idx(fold1), .mod_idx(mod1),
      .hvout_valid(ovalid[1]), .hvout_ready(oready[1]), .hvout(hvout_s[1]));

   function automatic int nm(input int u);
      return (u == 0) ? 3 : 2;
   endfunction

   function automatic int get_fold(input int u);
      return (u == 0) ? int'(fold0) : int'(fold1);
   endfunction

   function automatic int get_mod(input int u);
      return (u == 0) ? int'(mod0) : int'(mod1);
   endfunction

   // Reference: bit i is the majority of that bit across the modalities of fold i/4.
   function automatic logic [7:0] model(input beats_t bt, input int n);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         int f;
         int b;
         int c;
         f = i / 4;
         b = i % 4;
         c = 0;
         for (int m = 0; m < n; m++) c += int'(bt[f*n + m][b]);
         r[i] = (c > n / 2);
`ifdef BUNDLER_TIE_BREAK_EN
         if ((n % 2 == 0) && (c == n / 2)) r[i] = bt[f*n][b];
`endif
      end
      return r;
   endfunction

   function automatic beats_t rand_beats();
      beats_t bt;
      for (int k = 0; k < 6; k++) bt[k] = 4'($urandom);
      return bt;
   endfunction

   function automatic void push(input int u, input logic [7:0] v);
      if (u == 0) q0.push_back(v);
      else q1.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_beat(input int u, input logic [3:0] d, input int maxgap, input int k);
      int gaps;
      gaps = $urandom_range(0, maxgap);
      repeat (gaps) begin
         ivalid[u] = 1'b0;
         hvin_s[u] = 4'($urandom);
         @(negedge clk);
      end
      ivalid[u] = 1'b1;
      hvin_s[u] = d;
      for (int t = 0; t < 200; t++) begin
         #1;
         if (iready[u]) begin
            check($sformatf("u%0d beat%0d fold_idx", u, k), get_fold(u), k / nm(u));
            check($sformatf("u%0d beat%0d mod_idx", u, k), get_mod(u), k % nm(u));
            @(posedge clk);
            #1;
            ivalid[u] = 1'b0;
            return;
         end
         @(negedge clk);
      end
      checks++;
      failures++;
      $display("FAIL u%0d beat%0d accept timeout: hvin_ready stayed 0, required 1", u, k);
      ivalid[u] = 1'b0;
   endtask

   task automatic send_bundle(input int u, input beats_t bt, input logic [7:0] exp, input int maxgap);
      for (int k = 0; k < 2 * nm(u); k++) begin
         send_beat(u, bt[k], maxgap, k);
      end
      push(u, exp);
      last_hv[u] = exp;
      @(negedge clk);
      check($sformatf("u%0d hvout_valid one cycle after last accept", u), ovalid[u], 1);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         #1;
         if (q0.size() == 0 && q1.size() == 0 && ovalid == 2'b00) return;
      end
      checks++;
      failures++;
      $display("FAIL drain timeout: pending q0=%0d q1=%0d valid=%b, required none", q0.size(), q1.size(), ovalid);
   endtask

   // Abort unit 0 after n beats with a beat offered during the clear cycle; fold 0 is complete by then.
   task automatic clear_after(input int n);
      beats_t     bt;
      logic [7:0] m;
      bt = rand_beats();
      for (int k = 0; k < n; k++) send_beat(0, bt[k], 2, k);
      m = model(bt, 3);
      @(negedge clk);
      clear_s[0] = 1'b1;
      ivalid[0]  = 1'b1;
      hvin_s[0]  = 4'($urandom);
      #1;
      check("clear cycle hvin_ready", iready[0], 0);
      @(posedge clk);
      #1;
      clear_s[0] = 1'b0;
      ivalid[0]  = 1'b0;
      @(negedge clk);
      check("after clear fold_idx", fold0, 0);
      check("after clear mod_idx", mod0, 0);
      check("after clear hvout_valid", ovalid[0], 0);
      last_hv[0] = {last_hv[0][7:4], m[3:0]};
      check("after clear hvout kept", hvout_s[0], last_hv[0]);
   endtask

   // Back-pressure: random unless a directed phase forces a level.
   initial begin
      oready = 2'b00;
      forever begin
         @(posedge clk);
         #1;
         for (int u = 0; u < 2; u++) begin
            oready[u] = rdy_mode[u] ? rdy_force[u] : 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: pops one expectation per presented result, then checks it stays stable until consumed.
   initial begin
      forever begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            if (rst_n && ovalid[u]) begin
               if (!held[u]) begin
                  if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                     checks++;
                     failures++;
                     $display("FAIL u%0d unexpected result: got 0x%0h, required no result", u, hvout_s[u]);
                  end else begin
                     hv_exp[u] = (u == 0) ? q0.pop_front() : q1.pop_front();
                     check($sformatf("u%0d result", u), hvout_s[u], hv_exp[u]);
                  end
                  held[u] = 1'b1;
               end else begin
                  check($sformatf("u%0d hvout stable in HOLD", u), hvout_s[u], hv_exp[u]);
               end
               if (oready[u]) held[u] = 1'b0;
            end else begin
               held[u] = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global timeout: simulation still running, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      beats_t bt;
      clear_s   = 2'b00;
      ivalid    = 2'b00;
      hvin_s    = '{default: 4'h0};
      rdy_mode  = 2'b00;
      rdy_force = 2'b00;
      last_hv   = '{default: 8'h00};

      #12;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset hvout", u), hvout_s[u], 0);
         check($sformatf("u%0d reset hvout_valid", u), ovalid[u], 0);
         check($sformatf("u%0d reset fold_idx", u), get_fold(u), 0);
         check($sformatf("u%0d reset mod_idx", u), get_mod(u), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("first cycle after reset hvin_ready", iready, 2'b11);

      bt = '{4'hF, 4'h3, 4'h0, 4'h1, 4'h1, 4'h8};
      send_bundle(0, bt, 8'h13, 0);

      // Result held with ready low for 5 cycles while a beat is offered.
      wait_drain();
      rdy_mode[0]  = 1'b1;
      rdy_force[0] = 1'b0;
      bt = rand_beats();
      send_bundle(0, bt, model(bt, 3), 0);
      ivalid[0] = 1'b1;
      hvin_s[0] = 4'($urandom);
      repeat (5) begin
         @(negedge clk);
         #1;
         check("HOLD hvout_valid", ovalid[0], 1);
         check("HOLD hvin_ready", iready[0], 0);
      end
      rdy_force[0] = 1'b1;
      @(negedge clk);
      #1;
      check("handshake cycle hvin_ready", iready[0], 0);
      @(negedge clk);
      #1;
      ivalid[0] = 1'b0;
      check("after handshake hvout_valid", ovalid[0], 0);
      check("after handshake hvin_ready", iready[0], 1);
      check("after handshake fold_idx", fold0, 0);
      check("after handshake mod_idx", mod0, 0);

      // Clear while the result is held drops valid but keeps hvout.
      rdy_force[0] = 1'b0;
      bt = rand_beats();
      send_bundle(0, bt, model(bt, 3), 0);
      clear_s[0] = 1'b1;
      @(posedge clk);
      #1;
      clear_s[0] = 1'b0;
      @(negedge clk);
      check("clear in HOLD hvout_valid", ovalid[0], 0);
      check("clear in HOLD hvout kept", hvout_s[0], last_hv[0]);
      rdy_mode[0] = 1'b0;

      clear_after(4);
      bt = '{default: 4'hF};
      send_bundle(0, bt, 8'hFF, 1);
      clear_after(5);
      bt = rand_beats();
      send_bundle(0, bt, model(bt, 3), 1);

      // Asynchronous reset between edges in the middle of a bundle.
      wait_drain();
      bt = rand_beats();
      for (int k = 0; k < 3; k++) send_beat(0, bt[k], 1, k);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async reset hvout", hvout_s[0], 0);
      check("async reset fold_idx", fold0, 0);
      check("async reset mod_idx", mod0, 0);
      check("async reset hvout_valid", ovalid[0], 0);
      last_hv = '{default: 8'h00};
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bt = rand_beats();
      send_bundle(0, bt, model(bt, 3), 0);

      bt = '{4'hA, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
      send_bundle(1, bt, TIE_EXP, 0);

      // Concurrent random bundles with input gaps and random back-pressure.
      fork
         begin
            for (int n = 0; n < 25; n++) begin
               beats_t b0;
               b0 = rand_beats();
               send_bundle(0, b0, model(b0, 3), 3);
            end
         end
         begin
            for (int n = 0; n < 25; n++) begin
               beats_t b1;
               b1 = rand_beats();
               send_bundle(1, b1, model(b1, 2), 3);
            end
         end
      join

      wait_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
